cosim_event_queue: RTL and testbench
====================================

Name: cosim_event_queue

Overview:
- Per-hart capture-and-serialise stage between the core's retire/writeback trace signals and the co-simulation checker.
- Each cycle it accepts up to NCOMMIT commits, NWB register writebacks (integer or float) and one trap event, and packs them in a fixed order into a circular buffer.
- It drains one event per cycle to the checker over a valid/ready port, so the checker no longer has to sample pipeline-internal signals in the same cycle.
- It adds overflow detection, a commit-stall watchdog and an occupancy report.

Parameters:
- HARTID, 0, hart index echoed on out_hartid.
- NCOMMIT, 2, commit slots per cycle (1..4).
- NWB, 3, writeback slots per cycle (1..4).
- DEPTH, 16, buffer entries; power of two, and at least NCOMMIT+NWB+1.
- TIMEOUT, 100000, cycles without a commit before stall_timeout is set; 0 disables the watchdog.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- commit_valid  in  NCOMMIT  per-slot commit strobe.
- commit_pc  in  NCOMMIT*64  commit PC, sign-extended by the core.
- commit_insn  in  NCOMMIT*32  committed instruction bits.
- wb_valid  in  NWB  per-slot writeback strobe.
- wb_float  in  NWB  1 = FP register file, 0 = integer register file.
- wb_addr  in  NWB*5  destination register.
- wb_data  in  NWB*64  write data.
- trap_valid  in  1  interrupt or exception taken.
- trap_cause  in  64  cause value.
- out_valid  out  1  head entry valid.
- out_ready  in  1  checker accepts the head entry.
- out_kind  out  2  0 = commit, 1 = int wb, 2 = fp wb, 3 = trap.
- out_aux  out  32  insn for commits, zero-extended waddr for writebacks, 0 for traps.
- out_data  out  64  pc, wdata or cause.
- out_hartid  out  8  HARTID constant.
- occupancy  out  clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky: a cycle's events were dropped.
- stall_timeout  out  1  sticky: watchdog expired.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Pointers, occupancy, overflow, stall_timeout and the watchdog counter clear.
  - out_valid is 0.
  - Buffer contents are don't-care.
  - Reset mid-operation discards all pending entries, and events presented in the reset cycle are ignored.
- Packing order within a cycle:
  - Commit slots 0..NCOMMIT-1, then writeback slots 0..NWB-1, then trap.
  - Invalid slots are skipped.
  - The k-th valid event is written to wr_ptr+k, modulo DEPTH.
- Push count: n_in is the popcount of all valid strobes, in the range 0..NCOMMIT+NWB+1.
- Pop: pop = out_valid & out_ready.
- Space check uses free = DEPTH - occupancy + pop.
  - A same-cycle pop frees its slot for that cycle's push.
- Admission is all-or-nothing:
  - If n_in > free, none of that cycle's events are written and overflow is set and stays set until reset.
  - Partial acceptance is forbidden, because it would break ordering for the checker.
- Pointer and occupancy update:
  - occupancy' = occupancy + (accepted ? n_in : 0) - pop.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
- Latency:
  - An event presented at edge t can appear on out_* at cycle t+1 at the earliest. There is no bypass from input to output.
  - out_valid = (occupancy != 0).
  - out_* are driven from the head entry and stay stable while out_valid & !out_ready.
- Full: when occupancy == DEPTH with no pop, any n_in > 0 overflows. n_in == 0 is legal.
- Empty: out_valid = 0, and out_kind, out_aux and out_data are 0.
- Watchdog:
  - The counter increments each cycle in which no commit_valid bit is set, and clears in any cycle with a commit.
  - When the counter reaches TIMEOUT, stall_timeout is set and held until reset.
  - The counter saturates at TIMEOUT.
  - With TIMEOUT == 0 the counter is not instantiated and stall_timeout stays 0.
- Simultaneous push and pop at DEPTH occupancy with n_in == 1 is accepted, and occupancy stays at DEPTH.

Decomposition:
- Package cosim_pkg holds:
  - the event kind constants (EV_COMMIT = 0, EV_INT_WB = 1, EV_FP_WB = 2, EV_TRAP = 3);
  - the entry struct {kind[1:0], aux[31:0], data[63:0]}, 98 bits;
  - a popcount/prefix function.
- One sub-module, cosim_event_pack: the combinational prefix-sum compactor that maps the valid slots to write offsets 0..n_in-1 and produces n_in.
- The storage, pointers, watchdog and output stay in cosim_event_queue.

Test Plan:
- Single event: commit slot 0 with pc=0x80000000 and insn=0x00000013; out_ready=1.
  - Required: out_valid=1 on the next cycle with kind=0, aux=0x13, data=0x80000000; occupancy returns to 0 one cycle later.
- Ordering: one cycle with commit slot 1 (pc=0x80000004), int wb on slot 2 (addr=5, data=0xdead) and a trap with cause=0x8000000000000007; out_ready=1.
  - Required: three consecutive outputs with kinds 0, 1, 3; the wb entry has aux=5, data=0xdead.
- Backpressure and full: out_ready=0, DEPTH=16, push 16 single commits, then one more event.
  - Required: occupancy=16 and overflow=1 after the 17th event.
  - Draining then yields exactly the first 16 events in order, with out_* stable while stalled.
- All-or-nothing with pop: occupancy=14, out_ready=1 and 3 events presented (free=3).
  - Required: all 3 accepted, occupancy=16, overflow stays 0.
  - The same setup with 4 events requires none accepted, occupancy=13 and overflow=1.
- Watchdog: TIMEOUT=8, no commits.
  - Required: stall_timeout rises at the 8th idle cycle.
  - A commit before cycle 8 resets the count and keeps stall_timeout at 0.
- Mid-operation reset: occupancy=5, assert reset for one cycle.
  - Required: occupancy=0, out_valid=0, overflow=0; the next pushed event is output first.

Source files
------------

// File: rtl/cosim_pkg.sv
// rtl/cosim_pkg.sv - shared event kinds, queue entry layout and slot prefix count
package cosim_pkg;

  localparam logic [1:0] EV_COMMIT = 2'd0;
  localparam logic [1:0] EV_INT_WB = 2'd1;
  localparam logic [1:0] EV_FP_WB  = 2'd2;
  localparam logic [1:0] EV_TRAP   = 2'd3;

  // Largest slot vector: 4 commits + 4 writebacks + 1 trap.
  localparam int MAX_SLOTS = 9;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] aux;
    logic [63:0] data;
  } cosim_entry_t;

  // Number of set bits strictly below position upto; upto == MAX_SLOTS gives the full popcount.
  function automatic logic [3:0] prefix_count(input logic [MAX_SLOTS-1:0] v, input int upto);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      if (i < upto && v[i]) c = c + 4'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/cosim_event_queue_if.sv
// rtl/cosim_event_queue_if.sv - drain port from the event queue to the co-simulation checker
interface cosim_event_queue_if;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [31:0] out_aux;
  logic [63:0] out_data;
  logic [7:0]  out_hartid;

  modport master (
    output out_valid, out_kind, out_aux, out_data, out_hartid,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_kind, out_aux, out_data, out_hartid,
    output out_ready
  );
endinterface

// File: rtl/cosim_event_pack.sv
// rtl/cosim_event_pack.sv - compacts valid commit/writeback/trap slots into dense write offsets
module cosim_event_pack
  import cosim_pkg::*;
#(
  parameter int NCOMMIT = 2,
  parameter int NWB     = 3,
  localparam int NSLOT  = NCOMMIT + NWB + 1
) (
  input  logic [NCOMMIT-1:0]      commit_valid,
  input  logic [NWB-1:0]          wb_valid,
  input  logic                    trap_valid,
  output logic [NSLOT-1:0]        slot_valid,
  output logic [NSLOT-1:0][3:0]   slot_offset,
  output logic [3:0]              n_in
);

  logic [MAX_SLOTS-1:0] padded;

  assign slot_valid = {trap_valid, wb_valid, commit_valid};
  assign padded     = MAX_SLOTS'(slot_valid);

  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      slot_offset[s] = prefix_count(padded, s);
    end
    n_in = prefix_count(padded, MAX_SLOTS);
  end

endmodule

// File: rtl/cosim_event_queue.sv
// rtl/cosim_event_queue.sv - per-hart retire/writeback/trap capture buffer feeding the co-sim checker
module cosim_event_queue
  import cosim_pkg::*;
#(
  parameter int HARTID  = 0,
  parameter int NCOMMIT = 2,
  parameter int NWB     = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NCOMMIT-1:0]         commit_valid,
  input  logic [NCOMMIT*64-1:0]      commit_pc,
  input  logic [NCOMMIT*32-1:0]      commit_insn,
  input  logic [NWB-1:0]             wb_valid,
  input  logic [NWB-1:0]             wb_float,
  input  logic [NWB*5-1:0]           wb_addr,
  input  logic [NWB*64-1:0]          wb_data,
  input  logic                       trap_valid,
  input  logic [63:0]                trap_cause,
  cosim_event_queue_if.master        out,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow,
  output logic                       stall_timeout
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OW    = AW + 1;
  localparam int NSLOT = NCOMMIT + NWB + 1;

  logic [NSLOT-1:0]      slot_valid;
  logic [NSLOT-1:0][3:0] slot_offset;
  logic [3:0]            n_in;
  cosim_entry_t          slot_entry [NSLOT];
  cosim_entry_t          mem [DEPTH];
  cosim_entry_t          head;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  pop, accept;
  int                    free_cnt;

  cosim_event_pack #(.NCOMMIT(NCOMMIT), .NWB(NWB)) u_pack (
    .commit_valid (commit_valid),
    .wb_valid     (wb_valid),
    .trap_valid   (trap_valid),
    .slot_valid   (slot_valid),
    .slot_offset  (slot_offset),
    .n_in         (n_in)
  );

  always_comb begin
    for (int c = 0; c < NCOMMIT; c++) begin
      slot_entry[c] = '{kind: EV_COMMIT, aux: commit_insn[c*32 +: 32], data: commit_pc[c*64 +: 64]};
    end
    for (int w = 0; w < NWB; w++) begin
      slot_entry[NCOMMIT+w] = '{kind: (wb_float[w] ? EV_FP_WB : EV_INT_WB),
                                aux:  {27'd0, wb_addr[w*5 +: 5]},
                                data: wb_data[w*64 +: 64]};
    end
    slot_entry[NSLOT-1] = '{kind: EV_TRAP, aux: 32'd0, data: trap_cause};
  end

  // A pop in the same cycle frees its slot for this cycle's push; admission is all-or-nothing.
  assign pop      = out.out_valid & out.out_ready;
  assign free_cnt = DEPTH - int'(occupancy) + int'(pop);
  assign accept   = int'(n_in) <= free_cnt;

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (slot_valid[s]) mem[wr_ptr + AW'(slot_offset[s])] <= slot_entry[s];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr + AW'(pop);
      wr_ptr    <= wr_ptr + (accept ? AW'(n_in) : '0);
      occupancy <= occupancy + (accept ? OW'(n_in) : '0) - OW'(pop);
      if (!accept) overflow <= 1'b1;
    end
  end

  assign head           = mem[rd_ptr];
  assign out.out_valid  = (occupancy != '0);
  assign out.out_kind   = out.out_valid ? head.kind : 2'd0;
  assign out.out_aux    = out.out_valid ? head.aux  : 32'd0;
  assign out.out_data   = out.out_valid ? head.data : 64'd0;
  assign out.out_hartid = 8'(HARTID);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] wd_cnt, wd_next;
      logic          stall_q;

      always_comb begin
        wd_next = wd_cnt;
        if (|commit_valid)              wd_next = '0;
        else if (wd_cnt != TW'(TIMEOUT)) wd_next = wd_cnt + TW'(1);
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          wd_cnt  <= '0;
          stall_q <= 1'b0;
        end else begin
          wd_cnt <= wd_next;
          if (wd_next == TW'(TIMEOUT)) stall_q <= 1'b1;
        end
      end

      assign stall_timeout = stall_q;
    end else begin : g_no_wd
      assign stall_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cosim_event_queue.sv
// tb/tb_cosim_event_queue.sv - self-checking bench for cosim_event_queue against a queue model
module tb_cosim_event_queue;

  localparam int NC    = 2;
  localparam int NW    = 3;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] aux;
    logic [63:0] data;
  } ev_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [NC-1:0]    commit_valid;
  logic [NC*64-1:0] commit_pc;
  logic [NC*32-1:0] commit_insn;
  logic [NW-1:0]    wb_valid, wb_float;
  logic [NW*5-1:0]  wb_addr;
  logic [NW*64-1:0] wb_data;
  logic             trap_valid;
  logic [63:0]      trap_cause;
  logic [4:0]       occupancy;
  logic             overflow, stall_timeout;

  cosim_event_queue_if out_if ();

  cosim_event_queue #(.HARTID(3), .NCOMMIT(NC), .NWB(NW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_pc     (commit_pc),
    .commit_insn   (commit_insn),
    .wb_valid      (wb_valid),
    .wb_float      (wb_float),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .trap_valid    (trap_valid),
    .trap_cause    (trap_cause),
    .out           (out_if),
    .occupancy     (occupancy),
    .overflow      (overflow),
    .stall_timeout (stall_timeout)
  );

  always #5 clock = ~clock;

  int  n_checks = 0;
  int  n_pass   = 0;
  ev_t mq[$];
  bit  m_ovf, m_stall;
  int  m_idle;

  task automatic clear_inputs();
    commit_valid = '0; commit_pc = '0; commit_insn = '0;
    wb_valid = '0; wb_float = '0; wb_addr = '0; wb_data = '0;
    trap_valid = 1'b0; trap_cause = '0;
  endtask

  // Reference: events enter in slot order, a cycle is admitted whole or not at all.
  task automatic model_step();
    ev_t ev[$];
    ev_t e;
    int  free;
    bit  pop;
    if (!reset) begin
      mq.delete(); m_ovf = 0; m_stall = 0; m_idle = 0;
      return;
    end
    for (int c = 0; c < NC; c++)
      if (commit_valid[c]) begin
        e.kind = 2'd0; e.aux = commit_insn[c*32 +: 32]; e.data = commit_pc[c*64 +: 64]; ev.push_back(e);
      end
    for (int w = 0; w < NW; w++)
      if (wb_valid[w]) begin
        e.kind = wb_float[w] ? 2'd2 : 2'd1; e.aux = 32'(wb_addr[w*5 +: 5]); e.data = wb_data[w*64 +: 64]; ev.push_back(e);
      end
    if (trap_valid) begin
      e.kind = 2'd3; e.aux = 32'd0; e.data = trap_cause; ev.push_back(e);
    end
    pop  = (mq.size() != 0) && out_if.out_ready;
    free = DEPTH - mq.size() + int'(pop);
    if (pop) void'(mq.pop_front());
    if (ev.size() <= free) foreach (ev[i]) mq.push_back(ev[i]);
    else m_ovf = 1;
    if (commit_valid != '0) m_idle = 0;
    else if (m_idle < TMO) m_idle++;
    if (m_idle == TMO) m_stall = 1;
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push_commit(input logic [63:0] pc, input logic [31:0] insn);
    clear_inputs();
    commit_valid = 2'b01; commit_pc[63:0] = pc; commit_insn[31:0] = insn;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    out_if.out_ready = 1'b0;
    do_reset();
    n_checks++; if (out_if.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_if.out_valid); else n_pass++;
    n_checks++; if (occupancy !== 5'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else n_pass++;
    n_checks++; if (overflow !== 1'b0 || stall_timeout !== 1'b0)
      $display("FAIL reset_flags got ovf=%0b stall=%0b want 0/0", overflow, stall_timeout); else n_pass++;
    n_checks++; if ({out_if.out_kind, out_if.out_aux, out_if.out_data} !== 98'd0)
      $display("FAIL reset_empty_out got kind=%0d aux=%h data=%h want zeros", out_if.out_kind, out_if.out_aux, out_if.out_data); else n_pass++;
    n_checks++; if (out_if.out_hartid !== 8'd3) $display("FAIL hartid got %0d want 3", out_if.out_hartid); else n_pass++;
  endtask

  task automatic test_single();
    out_if.out_ready = 1'b1;
    push_commit(64'h8000_0000, 32'h0000_0013);
    n_checks++; if (out_if.out_valid !== 1'b1 || out_if.out_kind !== 2'd0 || out_if.out_aux !== 32'h13 || out_if.out_data !== 64'h8000_0000)
      $display("FAIL single_out got v=%0b k=%0d aux=%h data=%h want 1/0/13/80000000",
               out_if.out_valid, out_if.out_kind, out_if.out_aux, out_if.out_data); else n_pass++;
    tick();
    n_checks++; if (occupancy !== 5'd0 || out_if.out_valid !== 1'b0)
      $display("FAIL single_drain got occ=%0d v=%0b want 0/0", occupancy, out_if.out_valid); else n_pass++;
  endtask

  task automatic test_ordering();
    logic [1:0] exp_kind [3];
    exp_kind = '{2'd0, 2'd1, 2'd3};
    out_if.out_ready = 1'b1;
    clear_inputs();
    commit_valid = 2'b10; commit_pc[127:64] = 64'h8000_0004; commit_insn[63:32] = 32'h0010_0093;
    wb_valid = 3'b100; wb_addr[14:10] = 5'd5; wb_data[191:128] = 64'hdead;
    trap_valid = 1'b1; trap_cause = 64'h8000_0000_0000_0007;
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (out_if.out_valid !== 1'b1 || out_if.out_kind !== exp_kind[k])
        $display("FAIL order_kind%0d got v=%0b k=%0d want 1/%0d", k, out_if.out_valid, out_if.out_kind, exp_kind[k]); else n_pass++;
      if (k == 1) begin
        n_checks++; if (out_if.out_aux !== 32'd5 || out_if.out_data !== 64'hdead)
          $display("FAIL order_wb got aux=%h data=%h want 5/dead", out_if.out_aux, out_if.out_data); else n_pass++;
      end
      if (k == 2) begin
        n_checks++; if (out_if.out_data !== 64'h8000_0000_0000_0007 || out_if.out_aux !== 32'd0)
          $display("FAIL order_trap got aux=%h data=%h want 0/8000000000000007", out_if.out_aux, out_if.out_data); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_full_backpressure();
    do_reset();
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_commit(64'h1000 + 64'(4*i), 32'(i));
    n_checks++; if (occupancy !== 5'd16 || overflow !== 1'b0)
      $display("FAIL full_fill got occ=%0d ovf=%0b want 16/0", occupancy, overflow); else n_pass++;
    push_commit(64'h9999, 32'h99);
    n_checks++; if (occupancy !== 5'd16 || overflow !== 1'b1)
      $display("FAIL full_overflow got occ=%0d ovf=%0b want 16/1", occupancy, overflow); else n_pass++;
    for (int s = 0; s < 2; s++) begin
      tick();
      n_checks++; if (out_if.out_data !== 64'h1000 || out_if.out_aux !== 32'd0)
        $display("FAIL full_stable got data=%h aux=%h want 1000/0", out_if.out_data, out_if.out_aux); else n_pass++;
    end
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 64'h1000 + 64'(4*i) || out_if.out_aux !== 32'(i))
        $display("FAIL full_drain%0d got v=%0b data=%h aux=%h want 1/%h/%h", i, out_if.out_valid, out_if.out_data,
                 out_if.out_aux, 64'h1000 + 64'(4*i), i); else n_pass++;
      tick();
    end
    n_checks++; if (occupancy !== 5'd0 || overflow !== 1'b1)
      $display("FAIL full_after got occ=%0d ovf=%0b want 0/1", occupancy, overflow); else n_pass++;
  endtask

  task automatic test_mid_reset();
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_commit(64'h5000 + 64'(i), 32'(i));
    n_checks++; if (occupancy !== 5'd5) $display("FAIL midrst_pre got occ=%0d want 5", occupancy); else n_pass++;
    clear_inputs();
    commit_valid = 2'b01; commit_pc[63:0] = 64'h7777;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    clear_inputs();
    n_checks++; if (occupancy !== 5'd0 || out_if.out_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL midrst_clear got occ=%0d v=%0b ovf=%0b want 0/0/0", occupancy, out_if.out_valid, overflow); else n_pass++;
    push_commit(64'h3000, 32'h33);
    n_checks++; if (out_if.out_valid !== 1'b1 || out_if.out_data !== 64'h3000 || occupancy !== 5'd1)
      $display("FAIL midrst_first got v=%0b data=%h occ=%0d want 1/3000/1", out_if.out_valid, out_if.out_data, occupancy); else n_pass++;
  endtask

  task automatic test_all_or_nothing();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      out_if.out_ready = 1'b0;
      for (int i = 0; i < 14; i++) push_commit(64'h2000 + 64'(4*i), 32'(i));
      clear_inputs();
      out_if.out_ready = 1'b1;
      commit_valid = 2'b11; trap_valid = 1'b1; trap_cause = 64'd11;
      if (pass == 1) begin wb_valid = 3'b001; wb_addr[4:0] = 5'd9; end
      tick();
      clear_inputs();
      out_if.out_ready = 1'b0;
      if (pass == 0) begin
        n_checks++; if (occupancy !== 5'd16 || overflow !== 1'b0)
          $display("FAIL aon_fit got occ=%0d ovf=%0b want 16/0", occupancy, overflow); else n_pass++;
      end else begin
        n_checks++; if (occupancy !== 5'd13 || overflow !== 1'b1)
          $display("FAIL aon_reject got occ=%0d ovf=%0b want 13/1", occupancy, overflow); else n_pass++;
      end
      n_checks++; if (out_if.out_data !== 64'h2004)
        $display("FAIL aon_head%0d got data=%h want 2004", pass, out_if.out_data); else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 1; i <= TMO; i++) begin
      tick();
      n_checks++; if (stall_timeout !== (i >= TMO))
        $display("FAIL wd_idle%0d got %0b want %0b", i, stall_timeout, i >= TMO); else n_pass++;
    end
    do_reset();
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    push_commit(64'h4000, 32'h13);
    for (int i = 0; i < TMO - 1; i++) tick();
    n_checks++; if (stall_timeout !== 1'b0) $display("FAIL wd_cleared got %0b want 0", stall_timeout); else n_pass++;
    tick();
    n_checks++; if (stall_timeout !== 1'b1) $display("FAIL wd_after_commit got %0b want 1", stall_timeout); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++; if (occupancy !== 5'(mq.size()) || out_if.out_valid !== (mq.size() != 0))
        $display("FAIL rnd_occ@%0d got occ=%0d v=%0b want %0d", cyc, occupancy, out_if.out_valid, mq.size()); else n_pass++;
      n_checks++; if (overflow !== m_ovf || stall_timeout !== m_stall)
        $display("FAIL rnd_flags@%0d got ovf=%0b stall=%0b want %0b/%0b", cyc, overflow, stall_timeout, m_ovf, m_stall); else n_pass++;
      if (mq.size() != 0) begin
        n_checks++; if (out_if.out_kind !== mq[0].kind || out_if.out_aux !== mq[0].aux || out_if.out_data !== mq[0].data)
          $display("FAIL rnd_head@%0d got k=%0d aux=%h data=%h want k=%0d aux=%h data=%h", cyc, out_if.out_kind,
                   out_if.out_aux, out_if.out_data, mq[0].kind, mq[0].aux, mq[0].data); else n_pass++;
      end
      clear_inputs();
      commit_valid = NC'($urandom_range(0, 3) & $urandom_range(0, 3));
      wb_valid     = NW'($urandom_range(0, 7) & $urandom_range(0, 7));
      wb_float     = NW'($urandom);
      trap_valid   = ($urandom_range(0, 7) == 0);
      trap_cause   = {$urandom, $urandom};
      for (int c = 0; c < NC; c++) begin
        commit_pc[c*64 +: 64]   = {$urandom, $urandom};
        commit_insn[c*32 +: 32] = $urandom;
      end
      for (int w = 0; w < NW; w++) begin
        wb_addr[w*5 +: 5]  = 5'($urandom);
        wb_data[w*64 +: 64] = {$urandom, $urandom};
      end
      if ($urandom_range(0, 9) == 0) begin
        clear_inputs();
        if ($urandom_range(0, 1) == 0) commit_valid = 2'b01;
      end
      out_if.out_ready = (cyc % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (cyc == 300) reset = 1'b0;
      tick();
      reset = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b0;
    out_if.out_ready = 1'b0;
    clear_inputs();
    @(negedge clock);
    test_reset();
    test_single();
    test_ordering();
    test_full_backpressure();
    test_mid_reset();
    test_all_or_nothing();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
